// File: rtl/iiitb_pwm_duty_sequencer.sv
// Drives iiitb_pwm_gen's increase/decrease duty inputs with timed pulses until a
// requested duty step is reached, keeping a shadow copy of the generator's step.
module iiitb_pwm_duty_sequencer #(
  parameter int STEPS        = 10,
  parameter int RESET_STEP   = 5,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int STEP_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              target_valid,
  output logic              target_ready,
  input  logic [STEP_W-1:0] target_step,
  input  logic              abort,
  output logic              increase_duty,
  output logic              decrease_duty,
  output logic              busy,
  output logic [STEP_W-1:0] current_step,
  output logic              done,
  output logic              aborted
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  PULSE_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [STEP_W-1:0] STEP_MAX   = STEP_W'(STEPS);
  localparam logic [STEP_W-1:0] STEP_RST   = STEP_W'(RESET_STEP);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic [STEP_W-1:0] tgt_reg, tgt_next;
  logic [STEP_W-1:0] req_clamped;
  logic              dir_reg, dir_next;
  logic              abort_latch_reg, abort_latch_next;
  logic              done_reg, done_next;
  logic              aborted_reg, aborted_next;
  logic              inc_reg, inc_next;
  logic              dec_reg, dec_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      step_reg        <= STEP_RST;
      tgt_reg         <= STEP_RST;
      dir_reg         <= 1'b0;
      abort_latch_reg <= 1'b0;
      done_reg        <= 1'b0;
      aborted_reg     <= 1'b0;
      inc_reg         <= 1'b0;
      dec_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      step_reg        <= step_next;
      tgt_reg         <= tgt_next;
      dir_reg         <= dir_next;
      abort_latch_reg <= abort_latch_next;
      done_reg        <= done_next;
      aborted_reg     <= aborted_next;
      inc_reg         <= inc_next;
      dec_reg         <= dec_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    step_next        = step_reg;
    tgt_next         = tgt_reg;
    dir_next         = dir_reg;
    abort_latch_next = abort_latch_reg;
    done_next        = 1'b0;
    aborted_next     = 1'b0;
    // Clamping the target keeps every pulse inside 0..STEPS.
    req_clamped      = (target_step > STEP_MAX) ? STEP_MAX : target_step;

    case (state_reg)
      IDLE: begin
        abort_latch_next = 1'b0;
        if (target_valid) begin
          tgt_next = req_clamped;
          if (req_clamped == step_reg) begin
            done_next = 1'b1;
          end else begin
            dir_next   = (req_clamped > step_reg);
            state_next = PULSE;
            cnt_next   = PULSE_LOAD;
          end
        end
      end

      PULSE: begin
        if (abort) abort_latch_next = 1'b1;
        if (cnt_reg == CNT_ONE) begin
          step_next  = dir_reg ? (step_reg + STEP_ONE) : (step_reg - STEP_ONE);
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      GAP: begin
        if (abort) abort_latch_next = 1'b1;
        if (cnt_reg == CNT_ONE) begin
          // Reaching the target takes priority over a pending abort.
          if (step_reg == tgt_reg) begin
            state_next       = IDLE;
            done_next        = 1'b1;
            abort_latch_next = 1'b0;
          end else if (abort_latch_reg) begin
            state_next       = IDLE;
            aborted_next     = 1'b1;
            abort_latch_next = 1'b0;
          end else begin
            state_next = PULSE;
            cnt_next   = PULSE_LOAD;
          end
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    inc_next = (state_next == PULSE) && dir_next;
    dec_next = (state_next == PULSE) && !dir_next;
  end

  assign target_ready  = (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);
  assign increase_duty = inc_reg;
  assign decrease_duty = dec_reg;
  assign current_step  = step_reg;
  assign done          = done_reg;
  assign aborted       = aborted_reg;

endmodule
